lcd_timing_driver: RTL and testbench



---
 rtl/lcd_timing_pkg.sv | 41 ++++
 rtl/lcd_timing_driver_counter.sv | 49 ++++
 rtl/lcd_timing_driver.sv | 118 +++++++++++
 tb/tb_lcd_timing_driver.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared types and panel timing presets for the LCD timing driver.
//   lcd_state_t  : top-level run/idle state
//   P800_* / P480_* : 800x480 and 480x272 panel presets (pclk / lines)
//   H_TOTAL, V_TOTAL, H_ACT_START, V_ACT_START : derived values for the 800x480 preset
package lcd_timing_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} lcd_state_t;

  localparam int unsigned CNT_W = 11;

  // 800x480 preset
  localparam int unsigned P800_H_SYNC  = 128;
  localparam int unsigned P800_H_BACK  = 88;
  localparam int unsigned P800_H_DISP  = 800;
  localparam int unsigned P800_H_FRONT = 40;
  localparam int unsigned P800_V_SYNC  = 2;
  localparam int unsigned P800_V_BACK  = 33;
  localparam int unsigned P800_V_DISP  = 480;
  localparam int unsigned P800_V_FRONT = 10;

  // 480x272 preset
  localparam int unsigned P480_H_SYNC  = 41;
  localparam int unsigned P480_H_BACK  = 2;
  localparam int unsigned P480_H_DISP  = 480;
  localparam int unsigned P480_H_FRONT = 2;
  localparam int unsigned P480_V_SYNC  = 10;
  localparam int unsigned P480_V_BACK  = 2;
  localparam int unsigned P480_V_DISP  = 272;
  localparam int unsigned P480_V_FRONT = 2;

  function automatic int unsigned span_total(int unsigned s, int unsigned b,
                                             int unsigned d, int unsigned f);
    return s + b + d + f;
  endfunction

  localparam int unsigned H_TOTAL     = span_total(P800_H_SYNC, P800_H_BACK, P800_H_DISP, P800_H_FRONT);
  localparam int unsigned V_TOTAL     = span_total(P800_V_SYNC, P800_V_BACK, P800_V_DISP, P800_V_FRONT);
  localparam int unsigned H_ACT_START = P800_H_SYNC + P800_H_BACK;
  localparam int unsigned V_ACT_START = P800_V_SYNC + P800_V_BACK;

endpackage

// File: rtl/lcd_timing_driver_counter.sv
// One timing axis (horizontal or vertical): a 0..TOTAL-1 wrapping counter
// with its sync and active-window decodes.
//   clear        : hold count at 0 (dominates cnt_en)
//   cnt_en       : advance one step
//   count        : current position
//   wrap         : count is at TOTAL-1
//   sync_n       : low during the first SYNC positions
//   active       : ACT_START <= count < ACT_START+ACT_LEN
//   active_early : the same window shifted one position earlier
module lcd_sync_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned TOTAL     = 1056,
  parameter int unsigned SYNC      = 128,
  parameter int unsigned ACT_START = 216,
  parameter int unsigned ACT_LEN   = 800
) (
  input  logic             lcd_pclk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_n,
  output logic             active,
  output logic             active_early
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_W = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] A_LO   = CNT_W'(ACT_START);
  localparam logic [CNT_W-1:0] A_HI   = CNT_W'(ACT_START + ACT_LEN);
  // A zero ACT_START wraps E_LO to all-ones, which simply closes the early window.
  localparam logic [CNT_W-1:0] E_LO   = CNT_W'(ACT_START - 1);
  localparam logic [CNT_W-1:0] E_HI   = CNT_W'(ACT_START + ACT_LEN - 1);

  assign wrap = (count == LAST);

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (cnt_en) count <= wrap ? '0 : count + 1'b1;
  end

  assign sync_n       = (count >= SYNC_W);
  assign active       = (count >= A_LO) && (count < A_HI);
  assign active_early = (count >= E_LO) && (count < E_HI);

endmodule

// File: rtl/lcd_timing_driver.sv
// LCD timing generator and pixel-output stage.
// Generates request coordinates one cycle ahead of lcd_de so the upstream
// block's registered pixel_data lines up with the DE pixel, and drives the
// panel HS/VS/DE/RGB pins. Frames are never cut short: disp_en is only
// honoured at the end of a frame.
//   lcd_pclk, rst_n          : pixel clock, async active-low reset
//   disp_en                  : display enable (level)
//   pixel_data               : pixel returned by the upstream block
//   pixel_xpos/pixel_ypos    : requested column/row (0 outside the request)
//   h_disp/v_disp            : active size constants
//   data_req                 : pixel request, one cycle ahead of lcd_de
//   frame_start              : pulse at the first cycle of each frame
//   lcd_hs/lcd_vs/lcd_de/lcd_rgb : panel pins (syncs active low)
module lcd_timing_driver
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC  = P800_H_SYNC,
  parameter int unsigned H_BACK  = P800_H_BACK,
  parameter int unsigned H_DISP  = P800_H_DISP,
  parameter int unsigned H_FRONT = P800_H_FRONT,
  parameter int unsigned V_SYNC  = P800_V_SYNC,
  parameter int unsigned V_BACK  = P800_V_BACK,
  parameter int unsigned V_DISP  = P800_V_DISP,
  parameter int unsigned V_FRONT = P800_V_FRONT,
  parameter int unsigned WIDTH   = 24
) (
  input  logic             lcd_pclk,
  input  logic             rst_n,
  input  logic             disp_en,
  input  logic [WIDTH-1:0] pixel_data,
  output logic [10:0]      pixel_xpos,
  output logic [10:0]      pixel_ypos,
  output logic [10:0]      h_disp,
  output logic [10:0]      v_disp,
  output logic             data_req,
  output logic             frame_start,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [WIDTH-1:0] lcd_rgb
);

  localparam int unsigned H_TOT = span_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int unsigned V_TOT = span_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam int unsigned H_ACT = H_SYNC + H_BACK;
  localparam int unsigned V_ACT = V_SYNC + V_BACK;

  // The request window starts at H_ACT-1, so it needs at least one cycle of
  // sync+back porch in front of it; counters are 11 bits wide.
  if (H_ACT < 1 || H_TOT > 2047 || V_TOT > 2047) begin : g_param_check
    $error("lcd_timing_driver: illegal timing parameters");
  end

  lcd_state_t state, state_nxt;
  logic run;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, h_sync_n, h_active, h_early;
  logic v_wrap, v_sync_n, v_active, unused_v_early;

  assign run = (state == ST_RUN);

  lcd_sync_counter #(
    .TOTAL(H_TOT), .SYNC(H_SYNC), .ACT_START(H_ACT), .ACT_LEN(H_DISP)
  ) u_hcnt (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .clear(!run), .cnt_en(1'b1),
    .count(h_cnt), .wrap(h_wrap), .sync_n(h_sync_n),
    .active(h_active), .active_early(h_early)
  );

  lcd_sync_counter #(
    .TOTAL(V_TOT), .SYNC(V_SYNC), .ACT_START(V_ACT), .ACT_LEN(V_DISP)
  ) u_vcnt (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .clear(!run), .cnt_en(h_wrap),
    .count(v_cnt), .wrap(v_wrap), .sync_n(v_sync_n),
    .active(v_active), .active_early(unused_v_early)
  );

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (disp_en) state_nxt = ST_RUN;
      ST_RUN:  if (h_wrap && v_wrap && !disp_en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    lcd_hs      = 1'b1;
    lcd_vs      = 1'b1;
    lcd_de      = 1'b0;
    data_req    = 1'b0;
    frame_start = 1'b0;
    pixel_xpos  = '0;
    pixel_ypos  = '0;
    if (run) begin
      lcd_hs      = h_sync_n;
      lcd_vs      = v_sync_n;
      lcd_de      = h_active && v_active;
      data_req    = h_early && v_active;
      frame_start = (h_cnt == '0) && (v_cnt == '0);
      if (data_req) begin
        pixel_xpos = h_cnt - CNT_W'(H_ACT - 1);
        pixel_ypos = v_cnt - CNT_W'(V_ACT);
      end
    end
  end

  assign lcd_rgb = lcd_de ? pixel_data : '0;
  assign h_disp  = CNT_W'(H_DISP);
  assign v_disp  = CNT_W'(V_DISP);

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Bench for lcd_timing_driver: a default 800x480 instance (A) and a tiny
// 2/2/4/2 x 1/1/3/1 instance (B), both compared every cycle against a
// frame-position model (t = cycles since frame start).
module tb_lcd_timing_driver;

  logic lcd_pclk;
  initial lcd_pclk = 1'b0;
  always #5 lcd_pclk = ~lcd_pclk;

  int checks;
  int errors;

  // ---------------- instance A (default 800x480) ----------------
  logic        rstA, enA;
  logic [23:0] pdA, rgbA;
  logic [10:0] xA, yA, hdA, vdA;
  logic        reqA, fsA, hsA, vsA, deA;

  lcd_timing_driver dut_a (
    .lcd_pclk(lcd_pclk), .rst_n(rstA), .disp_en(enA), .pixel_data(pdA),
    .pixel_xpos(xA), .pixel_ypos(yA), .h_disp(hdA), .v_disp(vdA),
    .data_req(reqA), .frame_start(fsA), .lcd_hs(hsA), .lcd_vs(vsA),
    .lcd_de(deA), .lcd_rgb(rgbA)
  );

  // Upstream block: registers the requested column into a pixel.
  always @(posedge lcd_pclk) pdA <= {8'h12, 8'h34, xA[7:0]};

  // ---------------- instance B (tiny timing) ----------------
  logic        rstB, enB;
  logic [23:0] pdB, rgbB;
  logic [10:0] xB, yB, hdB, vdB;
  logic        reqB, fsB, hsB, vsB, deB;

  lcd_timing_driver #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1), .WIDTH(24)
  ) dut_b (
    .lcd_pclk(lcd_pclk), .rst_n(rstB), .disp_en(enB), .pixel_data(pdB),
    .pixel_xpos(xB), .pixel_ypos(yB), .h_disp(hdB), .v_disp(vdB),
    .data_req(reqB), .frame_start(fsB), .lcd_hs(hsB), .lcd_vs(vsB),
    .lcd_de(deB), .lcd_rgb(rgbB)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit hs, vs, de, req, fs;
    int x, y, col;
  } exp_t;

  function automatic exp_t predict(bit run, int t, int hs, int hb, int hd, int ht,
                                   int vs, int vb, int vd);
    exp_t e;
    int h, v;
    bit vin;
    h = t % ht;
    v = t / ht;
    e.hs = 1; e.vs = 1; e.de = 0; e.req = 0; e.fs = 0; e.x = 0; e.y = 0; e.col = 0;
    if (run) begin
      vin   = (v >= vs + vb) && (v < vs + vb + vd);
      e.hs  = (h >= hs);
      e.vs  = (v >= vs);
      e.de  = vin && (h >= hs + hb) && (h < hs + hb + hd);
      e.req = vin && (h >= hs + hb - 1) && (h < hs + hb + hd - 1);
      e.fs  = (t == 0);
      if (e.req) begin
        e.x = h - (hs + hb - 1);
        e.y = v - (vs + vb);
      end
      if (e.de) e.col = h - (hs + hb);
    end
    return e;
  endfunction

  localparam int A_FRAME = 1056 * 525;
  localparam int B_FRAME = 10 * 6;

  bit runA, runB;
  int tA, tB;

  always @(posedge lcd_pclk or negedge rstA)
    if (!rstA) begin runA <= 0; tA <= 0; end
    else if (!runA) begin if (enA) begin runA <= 1; tA <= 0; end end
    else if (tA == A_FRAME - 1) begin tA <= 0; if (!enA) runA <= 0; end
    else tA <= tA + 1;

  always @(posedge lcd_pclk or negedge rstB)
    if (!rstB) begin runB <= 0; tB <= 0; end
    else if (!runB) begin if (enB) begin runB <= 1; tB <= 0; end end
    else if (tB == B_FRAME - 1) begin tB <= 0; if (!enB) runB <= 0; end
    else tB <= tB + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_a();
    exp_t e;
    e = predict(runA, tA, 128, 88, 800, 1056, 2, 33, 480);
    cmp("A.hs",  32'(hsA),  32'(e.hs));
    cmp("A.vs",  32'(vsA),  32'(e.vs));
    cmp("A.de",  32'(deA),  32'(e.de));
    cmp("A.req", 32'(reqA), 32'(e.req));
    cmp("A.fs",  32'(fsA),  32'(e.fs));
    cmp("A.x",   32'(xA),   32'(e.x));
    cmp("A.y",   32'(yA),   32'(e.y));
    cmp("A.rgb", 32'(rgbA), e.de ? 32'({8'h12, 8'h34, 8'(e.col)}) : 32'd0);
  endtask

  task automatic check_b();
    exp_t e;
    e = predict(runB, tB, 2, 2, 4, 10, 1, 1, 3);
    cmp("B.hs",  32'(hsB),  32'(e.hs));
    cmp("B.vs",  32'(vsB),  32'(e.vs));
    cmp("B.de",  32'(deB),  32'(e.de));
    cmp("B.req", 32'(reqB), 32'(e.req));
    cmp("B.fs",  32'(fsB),  32'(e.fs));
    cmp("B.x",   32'(xB),   32'(e.x));
    cmp("B.y",   32'(yB),   32'(e.y));
    cmp("B.rgb", 32'(rgbB), e.de ? 32'(pdB) : 32'd0);
  endtask

  task automatic tick();
    @(posedge lcd_pclk);
    @(negedge lcd_pclk);
    check_a();
    check_b();
  endtask

  task automatic check_reset_b(input string nm);
    cmp({nm, ".hs"},  32'(hsB),  32'd1);
    cmp({nm, ".vs"},  32'(vsB),  32'd1);
    cmp({nm, ".de"},  32'(deB),  32'd0);
    cmp({nm, ".req"}, 32'(reqB), 32'd0);
    cmp({nm, ".fs"},  32'(fsB),  32'd0);
    cmp({nm, ".x"},   32'(xB),   32'd0);
    cmp({nm, ".y"},   32'(yB),   32'd0);
    cmp({nm, ".rgb"}, 32'(rgbB), 32'd0);
  endtask

  // Table of hand-derived B outputs, k = cycles since the first RUN cycle.
  typedef struct {
    int k;
    bit hs, vs, de, req, fs;
    int x, y;
  } vec_t;
  vec_t tbl[13];

  initial begin
    int fs_cnt, hs_low, vs_low, req_rise, de_rise, de_cnt, de_last;
    int x0, y0, x_end, kb, waited;
    checks = 0; errors = 0;
    tbl[0]  = '{0,  0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{2,  1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{13, 1, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{23, 1, 1, 0, 1, 0, 0, 0};
    tbl[4]  = '{24, 1, 1, 1, 1, 0, 1, 0};
    tbl[5]  = '{26, 1, 1, 1, 1, 0, 3, 0};
    tbl[6]  = '{27, 1, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{28, 1, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{33, 1, 1, 0, 1, 0, 0, 1};
    tbl[9]  = '{46, 1, 1, 1, 1, 0, 3, 2};
    tbl[10] = '{53, 1, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{59, 1, 1, 0, 0, 0, 0, 0};
    tbl[12] = '{60, 0, 0, 0, 0, 1, 0, 0};

    rstA = 0; rstB = 0; enA = 0; enB = 0; pdB = 24'h0;
    repeat (3) @(negedge lcd_pclk);
    rstA = 1; rstB = 1;

    // Idle after reset with disp_en low.
    for (int i = 0; i < 100; i++) tick();
    cmp("A.h_disp", 32'(hdA), 32'd800);
    cmp("A.v_disp", 32'(vdA), 32'd480);
    cmp("B.h_disp", 32'(hdB), 32'd4);
    cmp("B.v_disp", 32'(vdB), 32'd3);

    // Instance A: first frame through the first active line.
    enA = 1;
    fs_cnt = 0; hs_low = 0; vs_low = 0; req_rise = -1; de_rise = -1;
    de_cnt = 0; de_last = -1; x0 = -1; y0 = -1; x_end = -1;
    for (int k = 0; k < 36 * 1056 + 20; k++) begin
      tick();
      if (fsA) fs_cnt++;
      if (k < 1056 && !hsA) hs_low++;
      if (k < 3 * 1056 && !vsA) vs_low++;
      if (reqA && req_rise < 0) begin req_rise = k; x0 = 32'(xA); y0 = 32'(yA); end
      if (deA && de_rise < 0) de_rise = k;
      if (deA) begin de_cnt++; de_last = k; end
      if (k == 35 * 1056 + 1014) x_end = 32'(xA);
    end
    cmp("A.fs_count",   32'(fs_cnt),   32'd1);
    cmp("A.hs_low",     32'(hs_low),   32'd128);
    cmp("A.vs_low",     32'(vs_low),   32'd2112);
    cmp("A.req_rise",   32'(req_rise), 32'(35 * 1056 + 215));
    cmp("A.req_x0",     32'(x0),       32'd0);
    cmp("A.req_y0",     32'(y0),       32'd0);
    cmp("A.de_rise",    32'(de_rise),  32'(35 * 1056 + 216));
    cmp("A.x_end",      32'(x_end),    32'd799);
    cmp("A.de_last",    32'(de_last),  32'(35 * 1056 + 1015));
    cmp("A.de_count",   32'(de_cnt),   32'd800);

    // Asynchronous reset of A mid-frame.
    #1 rstA = 0;
    #1;
    cmp("A.rst.hs", 32'(hsA), 32'd1);
    cmp("A.rst.vs", 32'(vsA), 32'd1);
    cmp("A.rst.de", 32'(deA), 32'd0);
    enA = 0;

    // Instance B: table-driven first frame.
    enB = 1;
    kb = -1;
    for (int i = 0; i < 13; i++) begin
      while (kb < tbl[i].k) begin pdB = 24'($urandom); tick(); kb++; end
      cmp($sformatf("B.tbl%0d.hs", i),  32'(hsB),  32'(tbl[i].hs));
      cmp($sformatf("B.tbl%0d.vs", i),  32'(vsB),  32'(tbl[i].vs));
      cmp($sformatf("B.tbl%0d.de", i),  32'(deB),  32'(tbl[i].de));
      cmp($sformatf("B.tbl%0d.req", i), 32'(reqB), 32'(tbl[i].req));
      cmp($sformatf("B.tbl%0d.fs", i),  32'(fsB),  32'(tbl[i].fs));
      cmp($sformatf("B.tbl%0d.x", i),   32'(xB),   32'(tbl[i].x));
      cmp($sformatf("B.tbl%0d.y", i),   32'(yB),   32'(tbl[i].y));
    end

    // One full frame: 3 lines x 4 pixels, one frame_start.
    de_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 60; i++) begin tick(); if (deB) de_cnt++; if (fsB) fs_cnt++; end
    cmp("B.frame_de", 32'(de_cnt), 32'd12);
    cmp("B.frame_fs", 32'(fs_cnt), 32'd1);

    // Drop disp_en at v=1: frame completes, then idle.
    repeat (13) tick();
    enB = 0;
    de_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (deB) de_cnt++; if (fsB) fs_cnt++; end
    cmp("B.drain_de", 32'(de_cnt), 32'd12);
    cmp("B.drain_fs", 32'(fs_cnt), 32'd0);
    cmp("B.idle_hs",  32'(hsB),    32'd1);
    enB = 1;
    tick();
    cmp("B.restart_fs", 32'(fsB), 32'd1);

    // Drop and re-raise inside one frame: no interruption.
    repeat (5) tick();
    enB = 0;
    repeat (25) tick();
    enB = 1;
    fs_cnt = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (fsB) fs_cnt++; end
    cmp("B.reraise_fs", 32'(fs_cnt), 32'd1);

    // Asynchronous reset while DE is high.
    waited = 0;
    while (!deB && waited < 100) begin tick(); waited++; end
    cmp("B.wait_de", 32'(deB), 32'd1);
    pdB = 24'hABCDEF;
    #2 rstB = 0;
    #1 check_reset_b("B.async_rst");
    tick();
    check_reset_b("B.held_rst");
    rstB = 1;
    tick();
    cmp("B.post_rst_fs", 32'(fsB), 32'd1);

    // Random enable toggling, pixel data and occasional reset pulses.
    for (int i = 0; i < 4000; i++) begin
      pdB = 24'($urandom);
      if ($urandom_range(0, 39) == 0) enB = ~enB;
      if ($urandom_range(0, 499) == 0) begin
        #1 rstB = 0;
        #1 check_reset_b("B.rand_rst");
        rstB = 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
